arm_bus_regbank: RTL and testbench
==================================

Name: arm_bus_regbank

Overview:
- Parametrised ARM external-bus slave and control-register bank for the flaw-detector FPGA. It replaces the ad-hoc negedge-WE register decode in the top level.
- Synchronises the asynchronous ARM strobes into the clk domain.
- Commits writes to a bank of NUM_REGS registers, with per-register write strobes and atomic 32-bit register pairs.
- Drives read-back data and a one-cycle FIFO-pop strobe for the sample-readout address.

Parameters:
- DATA_W, 16, ARM data bus width.
- ADDR_W, 8, ARM address bus width.
- NUM_REGS, 16, number of writable registers.
- BASE_ADDR, 8'h04, address of register 0.
- ADDR_STRIDE, 4, address step between registers.
- PAIR_MASK, 16'h0001, bit i=1: reg i is the high half of a 32-bit pair whose low half is reg i+1.
- RESET_VAL, {NUM_REGS*DATA_W{1'b0}}, flattened per-register reset values.
- POP_ADDR, 8'h80, read address that generates pop_stb.
- SYNC_STAGES, 2, synchroniser depth for arm_ce_n/arm_we_n/arm_oe_n (>=2).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- arm_a  in  ADDR_W  ARM address.
- arm_d_in  in  DATA_W  ARM write data (from inout pad).
- arm_d_out  out  DATA_W  read data to pad.
- arm_d_oe  out  1  pad output enable.
- arm_ce_n  in  1  chip enable, active low.
- arm_oe_n  in  1  read strobe, active low.
- arm_we_n  in  1  write strobe, active low.
- ext_rd_data  in  DATA_W  read data for addresses outside the register window (status, FIFO data), muxed by top on arm_a.
- reg_q  out  NUM_REGS*DATA_W  committed register values, reg i at [i*DATA_W +: DATA_W].
- wr_stb  out  NUM_REGS  one-cycle pulse per register on commit.
- pop_stb  out  1  one-cycle pulse per read access at POP_ADDR.

Behaviour:
- Reset:
  - reg_q=RESET_VAL, shadows=0.
  - wr_stb=0, pop_stb=0.
  - Synchroniser and edge flops cleared to the inactive state.
  - Abandons any in-flight access; no commit follows reset release.
- Read path (combinational, asynchronous to clk):
  - arm_d_oe = ~arm_ce_n & ~arm_oe_n.
  - arm_d_out = reg_q of decoded reg if arm_a is in the window, else ext_rd_data.
  - A high-half register of a pair reads its committed value, never the shadow.
- Decode: a valid reg address is BASE_ADDR + k*ADDR_STRIDE, with k < NUM_REGS. Unaligned or out-of-window writes are ignored: no state change, no strobe.
- Write path:
  - wr_act = synchronised (~ce_n & ~we_n).
  - While wr_act=1, arm_a and arm_d_in are registered into hold regs every cycle. The last-sampled value is used.
  - Commit on the falling edge of wr_act, seen as wr_act_d=1 and wr_act=0. Registers and wr_stb update on the next clk edge.
  - Latency: commit is at most SYNC_STAGES+2 cycles after the ARM raises WE.
- Pairs (PAIR_MASK[i]=1):
  - Write to reg i loads shadow[i] only; no reg_q change, no strobe.
  - Write to reg i+1 loads reg_q[i]<=shadow[i] and reg_q[i+1]<=data in the same cycle, and pulses wr_stb[i] and wr_stb[i+1] together.
  - A low-half write without a preceding high write commits the stale shadow (the value from the last high write, or 0 after reset).
  - Repeated high writes overwrite the shadow; the last one wins.
- Read strobe:
  - rd_act = synchronised (~ce_n & ~oe_n).
  - On the rising edge of rd_act, with arm_a==POP_ADDR sampled that cycle, pop_stb=1 for exactly one cycle.
  - Exactly one pulse per ARM read, regardless of read length.
- Simultaneous events:
  - If wr_act and rd_act are both 1 (illegal bus state), the write proceeds and pop_stb is suppressed.
  - Back-to-back writes separated by at least 2 clk of WE high each commit in order.
  - Pulses shorter than SYNC_STAGES clk may be lost; the minimum ARM strobe width is SYNC_STAGES+1 clk.

Test Plan:
- Reset: assert reset with the bus idle -> reg_q==RESET_VAL, wr_stb==0, pop_stb==0, arm_d_oe==0.
- Single write: ARM writes 16'h0123 to 8'h0C (reg 2), WE low for 6 clk -> reg_q[2]==16'h0123 and wr_stb==0000_0000_0000_0100 for one cycle within SYNC_STAGES+2 clk of WE rise. Reading back 8'h0C returns 16'h0123 with arm_d_oe=1.
- Atomic pair:
  - Write 16'h0001 to 8'h04 (reg 0) -> reg_q[0] unchanged, no strobe.
  - Then write 16'hF400 to 8'h08 -> reg_q[0]==1 and reg_q[1]==16'hF400 in the same cycle, with wr_stb[1:0]==2'b11 in one pulse.
- Ignored writes: writes to 8'h06 (unaligned) and 8'h7C (out of window) -> no reg_q change, wr_stb stays 0. Reading 8'h84 returns ext_rd_data.
- Pop strobe: 100 consecutive reads at 8'h80, OE low 4 clk and high 3 clk each -> exactly 100 single-cycle pop_stb pulses. A read at 8'h84 -> no pulse. A read with WE also low -> no pulse.
- Reset mid-write: assert reset while WE is low at reg 3, release reset, then raise WE -> reg_q[3]==RESET_VAL[3] and no wr_stb.

Source files
------------

// File: rtl/arm_bus_regbank.sv
// ARM external-bus slave: strobe synchronisers, register bank with
// atomic 32-bit pairs, read-back mux and FIFO-pop strobe.
module arm_bus_regbank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_REGS = 16,
    parameter int BASE_ADDR = 'h04,
    parameter int ADDR_STRIDE = 4,
    parameter logic [NUM_REGS-1:0] PAIR_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1},
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
    parameter int POP_ADDR = 'h80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          arm_a,
    input  logic [DATA_W-1:0]          arm_d_in,
    output logic [DATA_W-1:0]          arm_d_out,
    output logic                       arm_d_oe,
    input  logic                       arm_ce_n,
    input  logic                       arm_oe_n,
    input  logic                       arm_we_n,
    input  logic [DATA_W-1:0]          ext_rd_data,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       pop_stb
);

    localparam int S = SYNC_STAGES;
    localparam logic [NUM_REGS-1:0] HI =
        PAIR_MASK & {1'b0, {(NUM_REGS-1){1'b1}}};
    localparam logic [NUM_REGS:0] HIX = {1'b0, HI};

    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] hit;
        hit = '0;
        for (int k = 0; k < NUM_REGS; k++)
            hit[k] = (int'(a) == BASE_ADDR + k * ADDR_STRIDE);
        return hit;
    endfunction

    logic [S-1:0]          ce_sr, we_sr, oe_sr, flush_sr;
    logic                  wr_act, rd_act, wr_act_d, rd_act_d;
    logic                  wr_arm, rd_arm, flushed, commit;
    logic [ADDR_W-1:0]     hold_a;
    logic [DATA_W-1:0]     hold_d;
    logic [DATA_W-1:0]     shadow [NUM_REGS];
    logic [NUM_REGS-1:0]   wdec, rdec;
    logic [NUM_REGS:0]     wdec_x;

    assign wr_act  = ~ce_sr[S-1] & ~we_sr[S-1];
    assign rd_act  = ~ce_sr[S-1] & ~oe_sr[S-1];
    assign flushed = flush_sr[S-1];
    assign commit  = wr_act_d & ~wr_act & wr_arm;
    assign wdec    = decode(hold_a);
    assign wdec_x  = {1'b0, wdec};
    assign rdec    = decode(arm_a);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_sr    <= '1;
            we_sr    <= '1;
            oe_sr    <= '1;
            flush_sr <= '0;
            wr_act_d <= 1'b0;
            rd_act_d <= 1'b0;
            wr_arm   <= 1'b0;
            rd_arm   <= 1'b0;
            hold_a   <= '0;
            hold_d   <= '0;
            pop_stb  <= 1'b0;
        end else begin
            ce_sr    <= {ce_sr[S-2:0], arm_ce_n};
            we_sr    <= {we_sr[S-2:0], arm_we_n};
            oe_sr    <= {oe_sr[S-2:0], arm_oe_n};
            flush_sr <= {flush_sr[S-2:0], 1'b1};
            wr_act_d <= wr_act;
            rd_act_d <= rd_act;
            // An access already under way at reset release is never honoured
            wr_arm   <= wr_arm | (flushed & ~wr_act);
            rd_arm   <= rd_arm | (flushed & ~rd_act);
            if (wr_act) begin
                hold_a <= arm_a;
                hold_d <= arm_d_in;
            end
            pop_stb  <= rd_act & ~rd_act_d & rd_arm & ~wr_act &
                        (int'(arm_a) == POP_ADDR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_q  <= RESET_VAL;
            wr_stb <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                shadow[k] <= '0;
        end else begin
            wr_stb <= '0;
            if (commit) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (HI[k] && wdec[k])
                        shadow[k] <= hold_d;
                    if (!HI[k] && wdec[k]) begin
                        reg_q[k*DATA_W +: DATA_W] <= hold_d;
                        wr_stb[k] <= 1'b1;
                    end
                    // Low-half write releases the shadowed high half
                    if (HI[k] && wdec_x[k+1] && !HIX[k+1]) begin
                        reg_q[k*DATA_W +: DATA_W] <= shadow[k];
                        wr_stb[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        arm_d_out = ext_rd_data;
        for (int k = 0; k < NUM_REGS; k++)
            if (rdec[k])
                arm_d_out = reg_q[k*DATA_W +: DATA_W];
    end

    assign arm_d_oe = ~arm_ce_n & ~arm_oe_n;

endmodule

// File: tb/tb_arm_bus_regbank.sv
// Directed bench for arm_bus_regbank: writes, pairs, ignored
// addresses, pop strobe and reset during a write.
module tb_arm_bus_regbank;

    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   arm_a;
    logic [15:0]  arm_d_in;
    logic [15:0]  arm_d_out;
    logic         arm_d_oe;
    logic         arm_ce_n, arm_oe_n, arm_we_n;
    logic [15:0]  ext_rd_data;
    logic [255:0] reg_q;
    logic [15:0]  wr_stb;
    logic         pop_stb;

    int checks = 0;
    int failures = 0;

    arm_bus_regbank dut (
        .clk(clk),
        .reset(reset),
        .arm_a(arm_a),
        .arm_d_in(arm_d_in),
        .arm_d_out(arm_d_out),
        .arm_d_oe(arm_d_oe),
        .arm_ce_n(arm_ce_n),
        .arm_oe_n(arm_oe_n),
        .arm_we_n(arm_we_n),
        .ext_rd_data(ext_rd_data),
        .reg_q(reg_q),
        .wr_stb(wr_stb),
        .pop_stb(pop_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rq(input int i);
        return reg_q[i*16 +: 16];
    endfunction

    task automatic bus_write(input string tag, input logic [7:0] a,
                             input logic [15:0] d, input logic [15:0] exp_stb);
        int npulse, late;
        logic [15:0] stb;
        arm_a = a;
        arm_d_in = d;
        arm_ce_n = 1'b0;
        arm_we_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        arm_we_n = 1'b1;
        arm_ce_n = 1'b1;
        npulse = 0;
        late = 0;
        stb = '0;
        for (int i = 0; i < S + 2; i++) begin
            @(posedge clk);
            #1;
            if (wr_stb != 0) begin
                npulse++;
                stb |= wr_stb;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (wr_stb != 0) late++;
        end
        check({tag, "_npulse"}, npulse, (exp_stb != 0) ? 1 : 0);
        check({tag, "_stb"}, stb, exp_stb);
        check({tag, "_late"}, late, 0);
    endtask

    task automatic bus_read(input logic [7:0] a, input logic we,
                            input int lo, input int hi,
                            output logic [15:0] d, output logic oe,
                            output int npop);
        arm_a = a;
        arm_ce_n = 1'b0;
        arm_oe_n = 1'b0;
        arm_we_n = ~we;
        npop = 0;
        d = '0;
        oe = 1'b0;
        for (int i = 0; i < lo; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                d = arm_d_out;
                oe = arm_d_oe;
            end
            if (pop_stb) npop++;
        end
        arm_oe_n = 1'b1;
        arm_ce_n = 1'b1;
        arm_we_n = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(posedge clk);
            #1;
            if (pop_stb) npop++;
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        oe;
        int          np, total, bad, mw;
        logic [255:0] snap;

        reset = 1'b1;
        arm_a = '0;
        arm_d_in = '0;
        arm_ce_n = 1'b1;
        arm_oe_n = 1'b1;
        arm_we_n = 1'b1;
        ext_rd_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_q", reg_q, '0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_pop", pop_stb, 0);
        check("rst_oe", arm_d_oe, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        bus_write("w_reg2", 8'h0C, 16'h0123, 16'h0004);
        check("reg2_val", rq(2), 16'h0123);
        bus_read(8'h0C, 1'b0, 4, 3, d, oe, np);
        check("rd_reg2", d, 16'h0123);
        check("rd_reg2_oe", oe, 1);

        bus_write("w_hi", 8'h04, 16'h0001, 16'h0000);
        check("hi_only_reg0", rq(0), 16'h0000);
        bus_read(8'h04, 1'b0, 4, 3, d, oe, np);
        check("rd_hi_committed", d, 16'h0000);
        bus_write("w_lo", 8'h08, 16'hF400, 16'h0003);
        check("pair_reg0", rq(0), 16'h0001);
        check("pair_reg1", rq(1), 16'hF400);
        bus_read(8'h04, 1'b0, 4, 3, d, oe, np);
        check("rd_reg0", d, 16'h0001);

        snap = {224'h0, 16'h0123, 16'hF400, 16'h0001};
        check("model_q", reg_q, snap);
        bus_write("w_unal", 8'h06, 16'hDEAD, 16'h0000);
        bus_write("w_oow", 8'h7C, 16'hDEAD, 16'h0000);
        check("ign_q", reg_q, snap);
        bus_read(8'h84, 1'b0, 4, 3, d, oe, np);
        check("rd_ext", d, 16'hBEEF);
        check("rd_ext_pop", np, 0);

        total = 0;
        bad = 0;
        for (int r = 0; r < 100; r++) begin
            bus_read(8'h80, 1'b0, 4, 3, d, oe, np);
            total += np;
            if (np != 1) bad++;
        end
        check("pop_total", total, 100);
        check("pop_bad_reads", bad, 0);
        bus_read(8'h84, 1'b0, 4, 3, d, oe, np);
        check("pop_other_addr", np, 0);
        bus_read(8'h80, 1'b1, 4, 6, d, oe, np);
        check("pop_with_we", np, 0);
        check("pop_we_q", reg_q, snap);

        arm_a = 8'h10;
        arm_d_in = 16'hAAAA;
        arm_ce_n = 1'b0;
        arm_we_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_stb", wr_stb, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        arm_we_n = 1'b1;
        arm_ce_n = 1'b1;
        mw = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wr_stb != 0) mw++;
        end
        check("mid_rst_pulses", mw, 0);
        check("mid_rst_reg3", rq(3), 16'h0000);
        check("mid_rst_q", reg_q, '0);

        bus_write("w_reg3", 8'h10, 16'h5A5A, 16'h0008);
        check("reg3_val", rq(3), 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
